// File: rtl/fpu_collect_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpu_collect_pkg
// Description : Shared types for the fpnew_top result collector.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_collect_pkg;

    localparam int STATUS_W      = 5;
    localparam int COLLECT_WIDTH = 16;
    localparam int COLLECT_TAG_W = 1;

    // Same layout as fpnew_pkg::status_t so fflags map 1:1 onto fcsr.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef struct packed {
        logic [COLLECT_WIDTH-1:0] result;
        status_t                  status;
        logic [COLLECT_TAG_W-1:0] tag;
    } collect_entry_t;

endpackage : fpu_collect_pkg
`default_nettype wire

// File: rtl/fpu_collect_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fpu_collect_fifo
// Description : Generic DEPTH-entry flop FIFO with push/pop/flush and level.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_collect_fifo #(
    parameter  int DATA_W = 22,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push;
    logic              do_pop;

    // Push/pop are qualified here so the FIFO never over/underflows.
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign level_o = level_q;

endmodule : fpu_collect_fifo
`default_nettype wire

// File: rtl/fpu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_collector
// Description : Buffers fpnew_top results, accumulates sticky fflags.
//               Optional perf counters under FPU_COLLECT_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_collector
    import fpu_collect_pkg::*;
#(
    parameter  int WIDTH = COLLECT_WIDTH,
    parameter  int DEPTH = 4,
    parameter  int TAG_W = COLLECT_TAG_W,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [WIDTH-1:0]    fpu_result_i,
    input  logic [STATUS_W-1:0] fpu_status_i,
    input  logic [TAG_W-1:0]    fpu_tag_i,
    input  logic                fpu_valid_i,
    output logic                fpu_ready_o,
    output logic [WIDTH-1:0]    res_o,
    output logic [STATUS_W-1:0] res_status_o,
    output logic [TAG_W-1:0]    res_tag_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [STATUS_W-1:0] fflags_o,
    input  logic                fflags_clr_i,
`ifdef FPU_COLLECT_PERF_EN
    output logic [31:0]         perf_results_o,
    output logic [31:0]         perf_stall_o,
`endif
    output logic [LVL_W-1:0]    level_o
);

    // Width-parameterised form of collect_entry_t.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        status_t          status;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t  wr_entry;
    entry_t  rd_entry;
    logic    full;
    logic    empty;
    logic    push_acc;
    logic    pop_acc;
    status_t fflags_q, fflags_d;

    assign wr_entry = '{result: fpu_result_i, status: status_t'(fpu_status_i), tag: fpu_tag_i};

    assign fpu_ready_o = ~full;
    assign res_valid_o = ~empty;
    assign push_acc    = fpu_valid_i & fpu_ready_o & ~flush_i;
    assign pop_acc     = res_valid_o & res_ready_i;

    fpu_collect_fifo #(
        .DATA_W ($bits(entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push_acc),
        .pop_i   (pop_acc),
        .data_i  (wr_entry),
        .data_o  (rd_entry),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    assign res_o        = rd_entry.result;
    assign res_status_o = rd_entry.status;
    assign res_tag_o    = rd_entry.tag;

    // Clear takes priority, then the accepted status is merged in.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i) fflags_d = '0;
        if (push_acc)     fflags_d = fflags_d | status_t'(fpu_status_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= '0;
        else         fflags_q <= fflags_d;
    end

    assign fflags_o = fflags_q;

`ifdef FPU_COLLECT_PERF_EN
    logic [31:0] perf_results_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_results_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push_acc)                   perf_results_q <= perf_results_q + 32'd1;
            if (fpu_valid_i & ~fpu_ready_o) perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end

    assign perf_results_o = perf_results_q;
    assign perf_stall_o   = perf_stall_q;
`endif

endmodule : fpu_result_collector
`default_nettype wire

// File: tb/tb_fpu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_result_collector
// Description : Self-checking bench for fpu_result_collector (queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_result_collector;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 1;

    typedef struct packed {
        logic [15:0] r;
        logic [4:0]  s;
        logic        t;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] fpu_res = '0;
    logic [4:0]  fpu_st = '0;
    logic        fpu_tag = 1'b0;
    logic        fpu_valid = 1'b0;
    logic        fpu_ready;
    logic [15:0] res;
    logic [4:0]  res_st;
    logic        res_tag;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [4:0]  fflags;
    logic        fflags_clr = 1'b0;
    logic [2:0]  level;
`ifdef FPU_COLLECT_PERF_EN
    logic [31:0] perf_results;
    logic [31:0] perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    ent_t        m_q[$];
    logic [4:0]  m_ff = '0;
    int unsigned m_perf_res = 0;
    int unsigned m_perf_stall = 0;

    always #5 clk = ~clk;

    fpu_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .fpu_result_i (fpu_res),
        .fpu_status_i (fpu_st),
        .fpu_tag_i    (fpu_tag),
        .fpu_valid_i  (fpu_valid),
        .fpu_ready_o  (fpu_ready),
        .res_o        (res),
        .res_status_o (res_st),
        .res_tag_o    (res_tag),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .fflags_o     (fflags),
        .fflags_clr_i (fflags_clr),
`ifdef FPU_COLLECT_PERF_EN
        .perf_results_o (perf_results),
        .perf_stall_o   (perf_stall),
`endif
        .level_o      (level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_level",  32'(level), 0);
        check_eq("rst_valid",  32'(res_valid), 0);
        check_eq("rst_ready",  32'(fpu_ready), 1);
        check_eq("rst_fflags", 32'(fflags), 0);
        check_eq("rst_res",    32'(res), 0);
        check_eq("rst_status", 32'(res_st), 0);
        check_eq("rst_tag",    32'(res_tag), 0);
    endtask

    task automatic compare_all();
        check_eq("level",  32'(level), m_q.size());
        check_eq("ready",  32'(fpu_ready), 32'(m_q.size() < DEPTH));
        check_eq("valid",  32'(res_valid), 32'(m_q.size() != 0));
        check_eq("fflags", 32'(fflags), 32'(m_ff));
        if (m_q.size() != 0) begin
            check_eq("res",    32'(res), 32'(m_q[0].r));
            check_eq("status", 32'(res_st), 32'(m_q[0].s));
            check_eq("tag",    32'(res_tag), 32'(m_q[0].t));
        end
`ifdef FPU_COLLECT_PERF_EN
        check_eq("perf_results", perf_results, m_perf_res);
        check_eq("perf_stall",   perf_stall, m_perf_stall);
`endif
    endtask

    // One clock cycle: drive, check current state, advance the model.
    task automatic cycle(input logic v, input logic [15:0] r, input logic [4:0] s,
                         input logic t, input logic rr, input logic fl, input logic clr);
        logic can_push, can_pop, did_push;
        fpu_valid  = v;
        fpu_res    = r;
        fpu_st     = s;
        fpu_tag    = t;
        res_ready  = rr;
        flush      = fl;
        fflags_clr = clr;
        compare_all();
        can_push = (m_q.size() < DEPTH);
        can_pop  = (m_q.size() != 0);
        did_push = v && can_push && !fl;
        @(posedge clk);
        #1;
        if (v && !can_push) m_perf_stall++;
        if (did_push)       m_perf_res++;
        if (clr)      m_ff = did_push ? s : 5'b0;
        else if (did_push) m_ff = m_ff | s;
        if (fl) begin
            m_q.delete();
        end else begin
            if (rr && can_pop) void'(m_q.pop_front());
            if (did_push)      m_q.push_back('{r: r, s: s, t: t});
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 16'h0, 5'h0, 1'b0, rr, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ff = '0;
        m_perf_res = 0;
        m_perf_stall = 0;
    endtask

    initial begin
        logic [15:0] d [5];
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        model_reset();

        // Single result 1.0*2.0.
        cycle(1'b1, 16'h4000, 5'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("single_res",   32'(res), 32'h4000);
        check_eq("single_valid", 32'(res_valid), 1);
        idle(1'b1);

        // Sticky overflow then clear.
        cycle(1'b1, 16'h7C00, 5'b00101, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h3C00, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check_eq("sticky_ff", 32'(fflags), 32'h5);
        cycle(1'b0, 16'h0, 5'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("clr_ff", 32'(fflags), 0);
        // Clear together with a push keeps only the new status.
        cycle(1'b1, 16'h1234, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h1235, 5'b10000, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("clr_push_ff", 32'(fflags), 32'h10);
        repeat (3) idle(1'b1);

        // Backpressure: 5 results into a 4-deep FIFO.
        for (int i = 0; i < 5; i++) d[i] = 16'h5000 + 16'(i);
        for (int i = 0; i < 4; i++) cycle(1'b1, d[i], 5'(i), 1'(i), 1'b0, 1'b0, 1'b0);
        check_eq("bp_level", 32'(level), 4);
        check_eq("bp_ready", 32'(fpu_ready), 0);
        repeat (2) cycle(1'b1, d[4], 5'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, d[4], 5'h4, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("bp_no_push_on_pop", 32'(level), 3);
        cycle(1'b1, d[4], 5'h4, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) idle(1'b1);

        // Push and pop together at level 2.
        for (int i = 0; i < 2; i++) cycle(1'b1, 16'(16'h6000 + i), 5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'($urandom), 5'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
            check_eq("pp_level", 32'(level), 2);
        end
        repeat (3) idle(1'b1);

        // Flush at level 3 together with a push.
        cycle(1'b1, 16'h7000, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 3; i++) cycle(1'b1, 16'(16'h7000 + i), 5'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h7777, 5'b00001, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("flush_level", 32'(level), 0);
        check_eq("flush_valid", 32'(res_valid), 0);
        check_eq("flush_ff",    32'(fflags), 32'h8);
        idle(1'b1);

        // Async reset mid-burst at level 2.
        for (int i = 0; i < 2; i++) cycle(1'b1, 16'(16'h7100 + i), 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0);
        fpu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, 16'($urandom), 5'($urandom), 1'($urandom),
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 5);
        end
        repeat (6) idle(1'b1);
        compare_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fpu_result_collector
`default_nettype wire
